// File: rtl/sram_ctrl_gen_pkg.sv
// +----------------------------------------------------------------------+
// | sram_ctrl_gen_pkg                                                     |
// | State encodings and sizing helpers shared by the SRAM controller.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package sram_ctrl_gen_pkg;

  localparam int c_ST_W = 2;

  localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_ST_W-1:0] c_ST_RD   = 2'd1;
  localparam logic [c_ST_W-1:0] c_ST_WR   = 2'd2;
  localparam logic [c_ST_W-1:0] c_ST_TURN = 2'd3;

  // Counter must hold the larger wait count, with one spare bit of headroom.
  function automatic int cnt_width(input int rd_cycles, input int wr_cycles);
    return $clog2((rd_cycles > wr_cycles) ? rd_cycles : wr_cycles) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_ctrl_gen_wait_cnt.sv
// +----------------------------------------------------------------------+
// | sram_ctrl_gen_wait_cnt                                                |
// | Loadable down-counter that holds at zero; exposes its next value.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_ctrl_gen_wait_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_next,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  assign zero = (r_count == '0);

  always_comb begin
    count_next = r_count;
    if (load)
      count_next = load_val;
    else if (!zero)
      count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else
      r_count <= count_next;
  end

endmodule

`default_nettype wire

// File: rtl/sram_ctrl_gen.sv
// +----------------------------------------------------------------------+
// | sram_ctrl_gen                                                         |
// | Async-SRAM controller with wait states, byte lanes, read turnaround. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_ctrl_gen
  import sram_ctrl_gen_pkg::*;
#(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic            ready,
  output logic [DW-1:0]   rdata,
  output logic            rd_valid,
  output logic            wr_done,
  output logic [DW-1:0]   rdata_ur,
  output logic [AW-1:0]   sram_addr,
  inout  wire  [DW-1:0]   sram_dq,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [DW/8-1:0] sram_be_n
);

  localparam int c_BW = DW / 8;
  localparam int c_CW = cnt_width(RD_CYCLES, WR_CYCLES);
  localparam logic [c_CW-1:0] c_RD_LOAD = c_CW'(RD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_WR_LOAD = c_CW'(WR_CYCLES - 1);

  if (RD_CYCLES < 1) begin : g_bad_rd_cycles
    $error("sram_ctrl_gen: RD_CYCLES must be at least 1");
  end
  if (WR_CYCLES < 2) begin : g_bad_wr_cycles
    $error("sram_ctrl_gen: WR_CYCLES must be at least 2");
  end
  if ((DW % 8) != 0) begin : g_bad_dw
    $error("sram_ctrl_gen: DW must be a multiple of 8");
  end

  logic [c_ST_W-1:0] r_state;
  logic [c_ST_W-1:0] w_state_next;
  logic              w_accept;
  logic              w_load;
  logic [c_CW-1:0]   w_load_val;
  logic [c_CW-1:0]   w_cnt_next;
  logic              w_cnt_zero;

  logic [DW-1:0]     r_wdata;
  logic [c_BW-1:0]   r_be;
  logic [c_BW-1:0]   w_be_nx;
  logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe;
  logic [c_BW-1:0]   r_be_n;
  logic              w_ce_n_nx, w_oe_n_nx, w_we_n_nx, w_dq_oe_nx;
  logic [c_BW-1:0]   w_be_n_nx;

  assign ready    = (r_state == c_ST_IDLE);
  assign w_accept = ready && req;

  sram_ctrl_gen_wait_cnt #(
    .WIDTH (c_CW)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_val   (w_load_val),
    .count_next (w_cnt_next),
    .zero       (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= c_ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      c_ST_IDLE: begin
        if (req) begin
          w_load = 1'b1;
          if (we) begin
            w_state_next = c_ST_WR;
            w_load_val   = c_WR_LOAD;
          end else begin
            w_state_next = c_ST_RD;
            w_load_val   = c_RD_LOAD;
          end
        end
      end
      c_ST_RD:   if (w_cnt_zero) w_state_next = c_ST_TURN;
      c_ST_WR:   if (w_cnt_zero) w_state_next = c_ST_IDLE;
      c_ST_TURN: w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so the pins flop in step with it.
  assign w_be_nx = w_accept ? be : r_be;

  always_comb begin
    w_ce_n_nx  = 1'b1;
    w_oe_n_nx  = 1'b1;
    w_we_n_nx  = 1'b1;
    w_be_n_nx  = {c_BW{1'b1}};
    w_dq_oe_nx = 1'b0;
    case (w_state_next)
      c_ST_RD: begin
        w_ce_n_nx = 1'b0;
        w_oe_n_nx = 1'b0;
        w_be_n_nx = '0;
      end
      c_ST_WR: begin
        w_ce_n_nx  = 1'b0;
        w_we_n_nx  = (w_cnt_next == '0);
        w_be_n_nx  = ~w_be_nx;
        w_dq_oe_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_be_n   <= {c_BW{1'b1}};
      r_dq_oe  <= 1'b0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      r_ce_n   <= w_ce_n_nx;
      r_oe_n   <= w_oe_n_nx;
      r_we_n   <= w_we_n_nx;
      r_be_n   <= w_be_n_nx;
      r_dq_oe  <= w_dq_oe_nx;
      rd_valid <= (r_state == c_ST_RD) && w_cnt_zero;
      wr_done  <= (r_state == c_ST_WR) && w_cnt_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_addr <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      rdata     <= '0;
    end else begin
      if (w_accept) begin
        sram_addr <= addr;
        r_wdata   <= wdata;
        r_be      <= be;
      end
      if ((r_state == c_ST_RD) && w_cnt_zero)
        rdata <= sram_dq;
    end
  end

  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_be_n = r_be_n;
  assign sram_dq   = r_dq_oe ? r_wdata : {DW{1'bz}};
  assign rdata_ur  = sram_dq;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_gen.sv
// +----------------------------------------------------------------------+
// | tb_sram_ctrl_gen                                                      |
// | Randomized bench: two controllers (2/2 and 4/3 waits) with SRAM models.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sram_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic        ready_a, rd_valid_a, wr_done_a, ce_n_a, oe_n_a, we_n_a;
  logic [15:0] rdata_a, rdata_ur_a;
  logic [17:0] sram_addr_a;
  logic [1:0]  be_n_a;
  wire  [15:0] sram_dq_a;

  logic        ready_b, rd_valid_b, wr_done_b, ce_n_b, oe_n_b, we_n_b;
  logic [15:0] rdata_b, rdata_ur_b;
  logic [17:0] sram_addr_b;
  logic [1:0]  be_n_b;
  wire  [15:0] sram_dq_b;

  int tests = 0;
  int fails = 0;
  bit sel   = 1'b0;

  always #5 clk = ~clk;

  sram_ctrl_gen #(.AW(18), .DW(16), .RD_CYCLES(2), .WR_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_a), .rdata(rdata_a), .rd_valid(rd_valid_a), .wr_done(wr_done_a),
    .rdata_ur(rdata_ur_a), .sram_addr(sram_addr_a), .sram_dq(sram_dq_a),
    .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .sram_be_n(be_n_a));

  sram_ctrl_gen #(.AW(18), .DW(16), .RD_CYCLES(4), .WR_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_b), .rdata(rdata_b), .rd_valid(rd_valid_b), .wr_done(wr_done_b),
    .rdata_ur(rdata_ur_b), .sram_addr(sram_addr_b), .sram_dq(sram_dq_b),
    .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .sram_be_n(be_n_b));

  // Async SRAM chips: drive the bus while selected with outputs enabled, write on we_n rise.
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  assign sram_dq_a = (!ce_n_a && !oe_n_a) ? mem_a[sram_addr_a] : 16'hzzzz;
  assign sram_dq_b = (!ce_n_b && !oe_n_b) ? mem_b[sram_addr_b] : 16'hzzzz;

  always @(posedge we_n_a)
    if (!reset && !ce_n_a)
      for (int l = 0; l < 2; l++)
        if (!be_n_a[l]) mem_a[sram_addr_a][l*8 +: 8] <= sram_dq_a[l*8 +: 8];

  always @(posedge we_n_b)
    if (!reset && !ce_n_b)
      for (int l = 0; l < 2; l++)
        if (!be_n_b[l]) mem_b[sram_addr_b][l*8 +: 8] <= sram_dq_b[l*8 +: 8];

  // While the chip drives the bus, anything else driving it would corrupt what is seen.
  always @(negedge clk) begin
    if (reset === 1'b0 && ce_n_a === 1'b0 && oe_n_a === 1'b0) begin
      tests++;
      if (rdata_ur_a !== mem_a[sram_addr_a]) begin
        fails++;
        $display("FAIL contention_a: bus=%h required %h", rdata_ur_a, mem_a[sram_addr_a]);
      end
    end
    if (reset === 1'b0 && ce_n_b === 1'b0 && oe_n_b === 1'b0) begin
      tests++;
      if (rdata_ur_b !== mem_b[sram_addr_b]) begin
        fails++;
        $display("FAIL contention_b: bus=%h required %h", rdata_ur_b, mem_b[sram_addr_b]);
      end
    end
  end

  logic        ready_s, rd_valid_s, wr_done_s, ce_s, oe_s, we_s;
  logic [1:0]  be_n_s;
  logic [15:0] rdata_s, dq_s;
  assign ready_s    = sel ? ready_b    : ready_a;
  assign rd_valid_s = sel ? rd_valid_b : rd_valid_a;
  assign wr_done_s  = sel ? wr_done_b  : wr_done_a;
  assign ce_s       = sel ? ce_n_b     : ce_n_a;
  assign oe_s       = sel ? oe_n_b     : oe_n_a;
  assign we_s       = sel ? we_n_b     : we_n_a;
  assign be_n_s     = sel ? be_n_b     : be_n_a;
  assign rdata_s    = sel ? rdata_b    : rdata_a;
  assign dq_s       = sel ? rdata_ur_b : rdata_ur_a;

  // Reference memory: what each SRAM should hold after all completed writes.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input bit s, input logic [17:0] a);
    int k = int'({s, a});
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
  endfunction

  task automatic ref_wr(input bit s, input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
    logic [15:0] v = ref_rd(s, a);
    for (int l = 0; l < 2; l++)
      if (b[l]) v[l*8 +: 8] = d[l*8 +: 8];
    ref_mem[int'({s, a})] = v;
  endtask

  task automatic set_req(input logic v);
    if (sel) req_b = v;
    else     req_a = v;
  endtask

  // One access on the selected controller, checking every cycle until ready returns.
  task automatic access(input bit w, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] b, input string nm);
    int rdc, wrc, n, guard;
    logic [15:0] exp_rd;
    logic [7:0]  obs, expv;
    rdc   = sel ? 4 : 2;
    wrc   = sel ? 3 : 2;
    guard = 0;
    while (ready_s !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (ready_s !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_wait: ready=%b required 1", nm, ready_s);
    end
    exp_rd = ref_rd(sel, a);
    we = w; addr = a; wdata = d; be = b;
    set_req(1'b1);
    @(negedge clk);
    set_req(1'b0);
    we = 1'($urandom); addr = 18'($urandom); wdata = 16'($urandom); be = 2'($urandom);
    n = w ? wrc : rdc + 1;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) @(negedge clk);
      if (w)
        expv = {(j < wrc) ? 1'b0 : 1'b1, 1'b1, (j < wrc - 1) ? 1'b0 : 1'b1,
                (j < wrc) ? ~b : 2'b11, 1'b0, (j == wrc), (j == wrc)};
      else
        expv = {(j < rdc) ? 1'b0 : 1'b1, (j < rdc) ? 1'b0 : 1'b1, 1'b1,
                (j < rdc) ? 2'b00 : 2'b11, (j == rdc), 1'b0, (j == rdc + 1)};
      obs = {ce_s, oe_s, we_s, be_n_s, rd_valid_s, wr_done_s, ready_s};
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL %s pins@%0d: {ce,oe,we,be_n,rv,wd,rdy}=%b required %b", nm, j, obs, expv);
      end
      if (w && j < wrc) begin
        tests++;
        if (dq_s !== d) begin
          fails++;
          $display("FAIL %s dq@%0d: bus=%h required %h", nm, j, dq_s, d);
        end
      end
      if (!w && j == rdc) begin
        tests++;
        if (rdata_s !== exp_rd) begin
          fails++;
          $display("FAIL %s rdata: got %h required %h", nm, rdata_s, exp_rd);
        end
      end
    end
    if (w) ref_wr(sel, a, d, b);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({ce_n_a, oe_n_a, we_n_a, be_n_a, rd_valid_a, wr_done_a, ready_a} !== 8'b11111001 ||
          rdata_a !== 16'h0 || sram_addr_a !== 18'h0) begin
        fails++;
        $display("FAIL reset_idle_a: pins=%b rdata=%h addr=%h required 11111001/0000/00000",
                 {ce_n_a, oe_n_a, we_n_a, be_n_a, rd_valid_a, wr_done_a, ready_a}, rdata_a, sram_addr_a);
      end
      tests++;
      if ({ce_n_b, oe_n_b, we_n_b, be_n_b, rd_valid_b, wr_done_b, ready_b} !== 8'b11111001 ||
          rdata_b !== 16'h0 || sram_addr_b !== 18'h0) begin
        fails++;
        $display("FAIL reset_idle_b: pins=%b rdata=%h addr=%h required 11111001/0000/00000",
                 {ce_n_b, oe_n_b, we_n_b, be_n_b, rd_valid_b, wr_done_b, ready_b}, rdata_b, sram_addr_b);
      end
    end
  endtask

  task automatic test_write_read;
    sel = 1'b0;
    access(1'b1, 18'h00123, 16'hA5C3, 2'b11, "wr_basic");
    access(1'b0, 18'h00123, 16'h0000, 2'b00, "rd_basic");
    tests++;
    if (rdata_a !== 16'hA5C3) begin
      fails++;
      $display("FAIL rd_basic_const: rdata=%h required a5c3", rdata_a);
    end
  endtask

  task automatic test_byte_lanes;
    sel = 1'b0;
    access(1'b1, 18'h3FFFF, 16'h1234, 2'b11, "lane_wr_full");
    access(1'b1, 18'h3FFFF, 16'hFFFF, 2'b01, "lane_wr_low");
    access(1'b1, 18'h3FFFF, 16'h0000, 2'b00, "lane_wr_none");
    access(1'b0, 18'h3FFFF, 16'h0000, 2'b00, "lane_rd");
    tests++;
    if (rdata_a !== 16'h12FF) begin
      fails++;
      $display("FAIL lane_rd_const: rdata=%h required 12ff", rdata_a);
    end
  endtask

  task automatic test_wait_states;
    sel = 1'b1;
    access(1'b1, 18'h00200, 16'hBEEF, 2'b11, "ws_wr");
    access(1'b0, 18'h00200, 16'h0000, 2'b00, "ws_rd");
    access(1'b0, 18'h00200, 16'h0000, 2'b00, "ws_rd2");
    access(1'b1, 18'h00201, 16'h7E81, 2'b10, "ws_wr2");
    access(1'b0, 18'h00201, 16'h0000, 2'b00, "ws_rd3");
    sel = 1'b0;
  endtask

  // Write issued with req held; a read is presented throughout the write and read.
  task automatic test_ignored;
    int nwd, nrv, noe;
    sel = 1'b0;
    nwd = 0; nrv = 0; noe = 0;
    we = 1'b1; addr = 18'h00300; wdata = 16'h5A3C; be = 2'b11; req_a = 1'b1;
    @(negedge clk);
    ref_wr(1'b0, 18'h00300, 16'h5A3C, 2'b11);
    we = 1'b0; wdata = 16'hFFFF;
    for (int j = 0; j <= 7; j++) begin
      if (j > 0) @(negedge clk);
      nwd += int'(wr_done_a);
      nrv += int'(rd_valid_a);
      noe += int'(!oe_n_a);
      tests++;
      if (ready_a !== ((j == 2) || (j == 6) || (j == 7))) begin
        fails++;
        $display("FAIL ignored_ready@%0d: ready=%b required %b", j, ready_a, (j == 2) || (j == 6) || (j == 7));
      end
      if (j == 5) begin
        tests++;
        if (rdata_a !== 16'h5A3C) begin
          fails++;
          $display("FAIL ignored_rdata: rdata=%h required 5a3c", rdata_a);
        end
      end
      if (j == 6) req_a = 1'b0;
    end
    tests++;
    if (nwd != 1 || nrv != 1 || noe != 2) begin
      fails++;
      $display("FAIL ignored_counts: wr_done=%0d rd_valid=%0d oe_cycles=%0d required 1/1/2", nwd, nrv, noe);
    end
  endtask

  task automatic test_reset_mid_write;
    sel = 1'b0;
    we = 1'b1; addr = 18'h00055; wdata = 16'hC0DE; be = 2'b11; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    tests++;
    if (we_n_a !== 1'b0 || ready_a !== 1'b0) begin
      fails++;
      $display("FAIL midrst_in_write: we_n=%b ready=%b required 0/0", we_n_a, ready_a);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({ce_n_a, oe_n_a, we_n_a, be_n_a, rd_valid_a, wr_done_a, ready_a} !== 8'b11111001) begin
      fails++;
      $display("FAIL midrst_async: pins=%b required 11111001",
               {ce_n_a, oe_n_a, we_n_a, be_n_a, rd_valid_a, wr_done_a, ready_a});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      tests++;
      if (wr_done_a !== 1'b0 || ready_a !== 1'b1) begin
        fails++;
        $display("FAIL midrst_hold@%0d: wr_done=%b ready=%b required 0/1", i, wr_done_a, ready_a);
      end
    end
    @(negedge clk);
    tests++;
    if (wr_done_a !== 1'b0 || ready_a !== 1'b1 || we_n_a !== 1'b1) begin
      fails++;
      $display("FAIL midrst_after: wr_done=%b ready=%b we_n=%b required 0/1/1", wr_done_a, ready_a, we_n_a);
    end
    access(1'b0, 18'h00123, 16'h0000, 2'b00, "midrst_rd");
  endtask

  task automatic test_random;
    for (int i = 0; i < 46; i++) begin
      sel = (i >= 30);
      access(1'($urandom), 18'h01000 + 18'($urandom_range(0, 7)), 16'($urandom), 2'($urandom),
             sel ? "rand_b" : "rand_a");
    end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we = 1'b0;
    addr  = '0;   wdata = '0;   be = '0;
    for (int i = 0; i < 262144; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_ignored();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
